hour_24: RTL and testbench
==========================

HOUR_24 -- requirements
Module: hour_24

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 hour_tick  input  1  one-cycle carry pulse from minutes-tens stage on 59->00 minute wrap.
REQ-004 set_req  input  1  time-set request, level, held by requester until set_ack seen.
REQ-005 set_hour_10  input  2  BCD tens digit to load, sampled while set_req=1 in IDLE.
REQ-006 set_hour_1  input  4  BCD ones digit to load, sampled with set_hour_10.
REQ-007 set_ack  output  1  one-cycle set completion pulse.
REQ-008 set_err  output  1  one-cycle pulse coincident with set_ack when requested value invalid.
REQ-009 hour_10  output  2  current hour tens digit, BCD.
REQ-010 hour_1  output  4  current hour ones digit, BCD.
REQ-011 day_tick  output  1  one-cycle carry pulse to day stage on 23->00 wrap.
REQ-012 pm  output  1  present only when HOUR_AMPM_EN defined; 1 for internal hours 12..23.

Function
REQ-013 Internal count SHALL be BCD pair (t,o), legal range 00..23; all outputs registered except 12h display mapping (REQ-030).
REQ-014 hour_tick=1, no accepted set: o<9 and not (t=2,o=3) -> o+1 next edge.
REQ-015 hour_tick=1, o=9 -> o=0, t+1 next edge (09->10, 19->20).
REQ-016 hour_tick=1 at 23 -> 00 and day_tick=1 for exactly that following cycle.
REQ-017 day_tick SHALL be 0 in every other cycle; latency hour_tick->count update = 1 cycle.
REQ-018 hour_tick=0 -> count holds.
REQ-019 Set FSM states: IDLE, DONE, WAIT_REL.
REQ-020 IDLE & set_req=1 -> validate inputs; valid iff set_hour_10<=2, set_hour_1<=9, and (set_hour_10<2 or set_hour_1<=3).
REQ-021 Valid -> count loads inputs at that edge; invalid -> count unchanged; either case -> DONE.
REQ-022 DONE: set_ack=1 (set_err=1 if rejected) for exactly one cycle -> WAIT_REL unconditionally.
REQ-023 WAIT_REL: stay while set_req=1; set_req=0 -> IDLE; no new set accepted until back in IDLE.
REQ-024 hour_tick in same cycle as accepted valid set: load wins, tick discarded, no day_tick.
REQ-025 hour_tick in same cycle as rejected set: tick applied normally.
REQ-026 hour_tick during DONE/WAIT_REL: counted normally.
REQ-027 Illegal count encodings unreachable; if ever present, next hour_tick SHALL force 00 without day_tick.

Reset
REQ-028 rst_n=0 -> immediately hour_10=0, hour_1=0, day_tick=0, set_ack=0, set_err=0, FSM=IDLE (pm=0 if present).
REQ-029 Reset mid-handshake aborts it; after release a still-high set_req is treated as a new request in IDLE.

Configuration
REQ-030 Macro HOUR_AMPM_EN defined: hour_10/hour_1 show 12h form (internal 00->12, 13..23->01..11, 12->12, 01..11 unchanged) and pm port exists; set inputs and day_tick stay 24h-based.
REQ-031 HOUR_AMPM_EN undefined: hour_10/hour_1 show internal 24h count directly; pm port absent.

Verification
REQ-032 Reset, then 23 hour_tick pulses -> count 23, no day_tick; 24th -> 00 with day_tick high one cycle.
REQ-033 Count 09, hour_tick -> 10; count 19, hour_tick -> 20.
REQ-034 set_req with 1/7 -> count 17 next edge, set_ack one cycle later, set_err=0; hold set_req 5 cycles with new data -> no reload; drop then reassert -> accepted.
REQ-035 set_req with 2/4, and separately 3/0 -> set_ack with set_err=1, count unchanged.
REQ-036 Count 23, set 0/5 with simultaneous hour_tick -> count 05, no day_tick; rejected set 2/9 with tick at 23 -> 00 plus day_tick.
REQ-037 HOUR_AMPM_EN build: set 0/0 -> display 12, pm=0; set 1/3 -> display 01, pm=1; assert rst_n low mid-DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hour_24_if.sv
// ---------------------------------------------------------------------------
// hour_24_if
//
// Purpose:
//   Time-set handshake between a requester and the hour_24 counter stage.
//   The requester holds set_req high with the BCD value on set_hour_10 and
//   set_hour_1. The counter answers with a one-cycle set_ack. When the value
//   was not a legal 24h hour, set_err pulses in the same cycle as set_ack.
//
// Signals:
//   set_req      requester -> counter  level request, held until set_ack
//   set_hour_10  requester -> counter  BCD tens digit to load (0..2 legal)
//   set_hour_1   requester -> counter  BCD ones digit to load (0..9 legal)
//   set_ack      counter -> requester  one-cycle completion pulse
//   set_err      counter -> requester  one-cycle reject pulse, with set_ack
//
// Modports:
//   master  the requester side
//   slave   the counter side (used by hour_24)
// ---------------------------------------------------------------------------
interface hour_24_if;
  logic       set_req;
  logic [1:0] set_hour_10;
  logic [3:0] set_hour_1;
  logic       set_ack;
  logic       set_err;

  modport master (
    output set_req,
    output set_hour_10,
    output set_hour_1,
    input  set_ack,
    input  set_err
  );

  modport slave (
    input  set_req,
    input  set_hour_10,
    input  set_hour_1,
    output set_ack,
    output set_err
  );
endinterface

// File: rtl/hour_24.sv
// ---------------------------------------------------------------------------
// hour_24
//
// Purpose:
//   Hours stage of a BCD clock chain. It keeps a 24h hour count as a BCD
//   pair (tens, ones) in the range 00..23. Each hour_tick_i pulse from the
//   minutes stage advances the count. On the 23 -> 00 wrap the stage emits
//   a one-cycle day_tick_o carry to the day stage. A small three-state
//   handshake (IDLE, DONE, WAIT_REL) lets a requester load a new hour
//   through the set interface.
//
// Ports:
//   clk          system clock, rising edge active
//   rst_n        asynchronous active-low reset
//   hour_tick_i  one-cycle carry from the minutes stage (59 -> 00)
//   set_if       slave side of the time-set handshake (see hour_24_if)
//   hour_10_o    displayed hour tens digit, BCD
//   hour_1_o     displayed hour ones digit, BCD
//   day_tick_o   one-cycle carry to the day stage on 23 -> 00
//   pm_o         afternoon flag (exists only with HOUR_AMPM_EN)
//
// Configuration:
//   HOUR_AMPM_EN  When this macro is defined, the hour outputs show the 12h
//                 form (00 -> 12, 13..23 -> 01..11) and pm_o is present.
//                 Loading and day_tick_o still work on the internal 24h
//                 count. When the macro is not defined, the outputs show the
//                 24h count directly and pm_o does not exist.
// ---------------------------------------------------------------------------
module hour_24 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hour_tick_i,
  hour_24_if.slave   set_if,
  output logic [1:0] hour_10_o,
  output logic [3:0] hour_1_o,
  output logic       day_tick_o
`ifdef HOUR_AMPM_EN
  ,
  output logic       pm_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DONE     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       day_q, day_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic       setAccept;
  logic       setValid;
  logic       loadSet;
  logic       countLegal;
  logic       atLastHour;

  // A request is taken only in IDLE. Holding set_req through DONE and
  // WAIT_REL therefore never reloads the count. The value is legal when it
  // is a real 24h hour: tens 0..2, ones 0..9, and ones 0..3 when tens is 2.
  always_comb begin
    setAccept  = (state_q == IDLE) && set_if.set_req;
    setValid   = (set_if.set_hour_10 <= 2'd2) &&
                 (set_if.set_hour_1 <= 4'd9) &&
                 ((set_if.set_hour_10 != 2'd2) || (set_if.set_hour_1 <= 4'd3));
    loadSet    = setAccept && setValid;
    countLegal = (tens_q != 2'd3) && (ones_q <= 4'd9) &&
                 ((tens_q != 2'd2) || (ones_q <= 4'd3));
    atLastHour = (tens_q == 2'd2) && (ones_q == 4'd3);
  end

  // Handshake sequencing. Acceptance moves to DONE, and DONE lasts exactly
  // one cycle. WAIT_REL then waits for the requester to release set_req, so
  // that one request produces one load. The ack and err pulses are
  // registered on the accepting edge, which puts them high in the DONE
  // cycle.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (set_if.set_req) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = !setValid;
        end
      end
      DONE: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!set_if.set_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hour counter. An accepted legal load takes priority over a coincident
  // tick, and that tick is dropped without any carry. A rejected load leaves
  // the count to the normal tick path. A corrupted encoding is repaired to
  // 00 by the next tick, and this repair is not a day wrap, so no carry is
  // sent.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    day_d  = 1'b0;
    if (loadSet) begin
      tens_d = set_if.set_hour_10;
      ones_d = set_if.set_hour_1;
    end else if (hour_tick_i) begin
      if (!countLegal) begin
        tens_d = 2'd0;
        ones_d = 4'd0;
      end else if (atLastHour) begin
        tens_d = 2'd0;
        ones_d = 4'd0;
        day_d  = 1'b1;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 2'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // All state registers, cleared asynchronously. Reset aborts a handshake
  // in progress. If set_req is still high after release, it is seen again
  // in IDLE as a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tens_q  <= 2'd0;
      ones_q  <= 4'd0;
      day_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      day_q   <= day_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign set_if.set_ack = ack_q;
  assign set_if.set_err = err_q;
  assign day_tick_o     = day_q;

`ifdef HOUR_AMPM_EN
  // 12h display mapping, done in BCD directly from the count registers.
  // Internal 00 shows as 12, so the display is forced to zero while reset
  // is asserted. Without this, the outputs would read 12 during reset.
  always_comb begin
    hour_10_o = tens_q;
    hour_1_o  = ones_q;
    if (!rst_n) begin
      hour_10_o = 2'd0;
      hour_1_o  = 4'd0;
    end else if ((tens_q == 2'd0) && (ones_q == 4'd0)) begin
      hour_10_o = 2'd1;
      hour_1_o  = 4'd2;
    end else if ((tens_q == 2'd1) && (ones_q >= 4'd3)) begin
      hour_10_o = 2'd0;
      hour_1_o  = ones_q - 4'd2;
    end else if ((tens_q == 2'd2) && (ones_q <= 4'd1)) begin
      hour_10_o = 2'd0;
      hour_1_o  = ones_q + 4'd8;
    end else if (tens_q == 2'd2) begin
      hour_10_o = 2'd1;
      hour_1_o  = ones_q - 4'd2;
    end
  end

  // Afternoon covers internal hours 12..23.
  assign pm_o = (tens_q == 2'd2) || ((tens_q == 2'd1) && (ones_q >= 4'd2));
`else
  assign hour_10_o = tens_q;
  assign hour_1_o  = ones_q;
`endif

endmodule

// File: tb/tb_hour_24.sv
// ---------------------------------------------------------------------------
// tb_hour_24
//
// Purpose:
//   Randomised and directed stimulus for hour_24. A reference model holds
//   the hour as a plain integer (0..23) and tracks the handshake phase. It
//   pushes the expected outputs for every cycle into a queue. Separate
//   monitor processes pop from that queue and compare against the DUT.
// ---------------------------------------------------------------------------
module tb_hour_24;

  typedef struct packed {
    logic [1:0] h10;
    logic [3:0] h1;
    logic       pm;
    logic       day;
    logic       ack;
    logic       err;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       hourTick;
  logic [1:0] hour10;
  logic [3:0] hour1;
  logic       dayTick;
  logic       pmOut;

  int         total = 0;
  int         bad   = 0;

  obs_t       expQ[$];
  bit         ackQ[$];

  int         mHour;
  int         mPhase;

  obs_t       monAct;
  obs_t       monExp;
  bit         monErr;

  hour_24_if setBus ();

  hour_24 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hour_tick_i(hourTick),
    .set_if     (setBus),
    .hour_10_o  (hour10),
    .hour_1_o   (hour1),
    .day_tick_o (dayTick)
`ifdef HOUR_AMPM_EN
    ,
    .pm_o       (pmOut)
`endif
  );

`ifndef HOUR_AMPM_EN
  assign pmOut = 1'b0;
`endif

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds the expected visible outputs from a 24h hour value.
  function automatic obs_t makeObs(input int h, input bit day, input bit ack,
                                   input bit err);
    obs_t o;
    int   shown;
    bit   isPm;
`ifdef HOUR_AMPM_EN
    shown = (h % 12 == 0) ? 12 : (h % 12);
    isPm  = (h >= 12);
`else
    shown = h;
    isPm  = 1'b0;
`endif
    o.h10 = 2'(shown / 10);
    o.h1  = 4'(shown % 10);
    o.pm  = isPm;
    o.day = day;
    o.ack = ack;
    o.err = err;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Reference model. The hour is an integer that advances modulo 24. The
  // handshake phase is 0 when free, 1 during the ack cycle, and 2 while
  // waiting for release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHour  = 0;
      mPhase = 0;
      expQ.delete();
      ackQ.delete();
    end else begin
      bit day;
      bit ack;
      bit err;
      bit loaded;
      int t;
      int o;
      day    = 0;
      ack    = 0;
      err    = 0;
      loaded = 0;
      t      = int'(setBus.set_hour_10);
      o      = int'(setBus.set_hour_1);
      if (mPhase == 0 && setBus.set_req) begin
        ack    = 1;
        err    = !(t <= 2 && o <= 9 && (t * 10 + o) <= 23);
        mPhase = 1;
        if (!err) begin
          mHour  = t * 10 + o;
          loaded = 1;
        end
      end else if (mPhase == 1) begin
        mPhase = 2;
      end else if (mPhase == 2 && !setBus.set_req) begin
        mPhase = 0;
      end
      if (hourTick && !loaded) begin
        day   = (mHour == 23);
        mHour = (mHour + 1) % 24;
      end
      expQ.push_back(makeObs(mHour, day, ack, err));
      if (ack) ackQ.push_back(err);
    end
  end

  // Monitor. Each active cycle is compared with the next expected entry.
  // Every acknowledgement the DUT raises is also matched against a pending
  // request.
  always @(negedge clk) begin
    if (rst_n) begin
      monAct = '{h10: hour10, h1: hour1, pm: pmOut, day: dayTick,
                 ack: setBus.set_ack, err: setBus.set_err};
      if (expQ.size() == 0) begin
        checkOutput("scoreboard underflow", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("cycle outputs", 32'(monAct), 32'(monExp));
      end
      if (setBus.set_ack === 1'b1) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpected set_ack", 32'd1, 32'd0);
        end else begin
          monErr = ackQ.pop_front();
          checkOutput("set_err with ack", 32'(setBus.set_err), 32'(monErr));
        end
      end
    end
  end

  task automatic applyStimulus(input bit tick, input bit req, input int t,
                               input int o);
    @(negedge clk);
    hourTick           = tick;
    setBus.set_req     = req;
    setBus.set_hour_10 = 2'(t);
    setBus.set_hour_1  = 4'(o);
  endtask

  // Full set handshake. Request, hold through DONE, then release.
  task automatic doSet(input int t, input int o, input bit tick);
    applyStimulus(tick, 1, t, o);
    applyStimulus(0, 1, t, o);
    applyStimulus(0, 0, t, o);
    applyStimulus(0, 0, t, o);
  endtask

  initial begin
    bit reqLevel;
    int rt;
    int ro;
    rst_n              = 1'b0;
    hourTick           = 1'b0;
    setBus.set_req     = 1'b0;
    setBus.set_hour_10 = 2'd0;
    setBus.set_hour_1  = 4'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    $display("[TB] reset released");

    // Full day of ticks from reset, including the 23 -> 00 carry.
    repeat (24) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Tens rollover from 09 and from 19.
    doSet(0, 9, 0);
    applyStimulus(1, 0, 0, 0);
    doSet(1, 9, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Hold set_req with changing data: only the first value loads.
    applyStimulus(0, 1, 1, 7);
    repeat (5) applyStimulus(0, 1, 0, 2);
    applyStimulus(0, 0, 0, 2);
    doSet(0, 2, 0);

    // Rejected values.
    doSet(2, 4, 0);
    doSet(3, 0, 0);

    // Load and tick in the same cycle, for accepted and rejected loads.
    doSet(2, 3, 0);
    doSet(0, 5, 1);
    doSet(2, 3, 0);
    doSet(2, 9, 1);

    // 12h-relevant values: midnight and 13h.
    doSet(0, 0, 0);
    doSet(1, 3, 0);

    // Reset asserted during the DONE cycle, with set_req still high after
    // release.
    applyStimulus(0, 1, 1, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset hour_10", 32'(hour10), 32'd0);
    checkOutput("reset hour_1", 32'(hour1), 32'd0);
    checkOutput("reset day_tick", 32'(dayTick), 32'd0);
    checkOutput("reset set_ack", 32'(setBus.set_ack), 32'd0);
    checkOutput("reset set_err", 32'(setBus.set_err), 32'd0);
    checkOutput("reset pm", 32'(pmOut), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Random ticks and requests, including ticks during DONE and WAIT_REL.
    reqLevel = 0;
    rt       = 0;
    ro       = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!reqLevel) begin
        if ($urandom_range(0, 5) == 0) begin
          reqLevel = 1;
          if ($urandom_range(0, 3) != 0) begin
            rt = $urandom_range(0, 2);
            ro = (rt == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9);
          end else begin
            rt = $urandom_range(0, 3);
            ro = $urandom_range(0, 15);
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        reqLevel = 0;
      end else if ($urandom_range(0, 4) == 0) begin
        ro = $urandom_range(0, 15);
      end
      applyStimulus(($urandom_range(0, 2) == 0), reqLevel, rt, ro);
    end

    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("pending acks drained", 32'(ackQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
